// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - handshaked ALU with single-cycle ops and iterative multiply/divide
//
// Optional feature macro: PIPELINED_ALU_DIV_EN (adds the DIV state and the restoring divider).
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   reset_n     asynchronous active-low reset
//   in_valid    request valid            in_ready   request can be taken this cycle
//   inA, inB    operands                 ALUControl operation select (4 bits)
//   out_valid   result valid             out_ready  consumer takes the result this cycle
//   out         registered result        zero       registered, out == 0
//   overflow    registered signed overflow of ADD/SUB
//   busy        multiply/divide iteration in progress
module pipelined_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             busy
);

`ifdef PIPELINED_ALU_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1} state_t;
`endif

    localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] opb;      // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] hi;       // product high half / partial remainder
    logic [WIDTH-1:0] lo;       // multiplier being shifted out / quotient being shifted in
    logic             hi_sel;   // result comes from hi (MULHU, REMU)

    logic             accept;
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             is_mul;
    logic             is_div;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;

    logic             load;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // One adder serves ADD, SUB and SLT; subtraction is A + ~B + 1.
    assign sub     = (ALUControl == 4'b0110) || (ALUControl == 4'b0111);
    assign b_eff   = sub ? ~inB : inB;
    assign sum     = inA + b_eff + WIDTH'(sub);
    assign add_ovf = (inA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != inA[WIDTH-1]);
    assign sh      = inB[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        is_mul  = 1'b0;
        is_div  = 1'b0;
        case (ALUControl)
            4'b0000: alu_res = inA & inB;
            4'b0001: alu_res = inA | inB;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            4'b0100: alu_res = inA ^ inB;
            4'b0101: alu_res = ~(inA ^ inB);
            4'b0110: begin
                alu_res = sum;
                alu_ovf = add_ovf;
            end
            // Sign of A-B flipped when the subtraction overflowed gives the true signed compare.
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
            4'b1000: alu_res = inA << sh;
            4'b1001: alu_res = inA >> sh;
            4'b1010: alu_res = $signed(inA) >>> sh;
            4'b1100, 4'b1101: is_mul = 1'b1;
`ifdef PIPELINED_ALU_DIV_EN
            4'b1110, 4'b1111: is_div = 1'b1;
`endif
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift the
    // whole {hi, lo} product right by one. After WIDTH steps {hi, lo} = A * B.
    assign mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? opb : {WIDTH{1'b0}})};
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo[WIDTH-1:1]};

`ifdef PIPELINED_ALU_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder and subtract the
    // divisor when it fits. A zero divisor always "fits", which yields an all-ones
    // quotient and leaves the dividend in the remainder.
    logic [WIDTH:0]   div_part;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    assign div_part = {hi, lo[WIDTH-1]};
    assign div_ge   = div_part >= {1'b0, opb};
    assign div_diff = {hi[WIDTH-2:0], lo[WIDTH-1]} - opb;
    assign div_hi_n = div_ge ? div_diff : div_part[WIDTH-1:0];
    assign div_lo_n = {lo[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        res_d     = '0;
        ovf_d     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_nxt = MUL;
`ifdef PIPELINED_ALU_DIV_EN
                    end else if (is_div) begin
                        state_nxt = DIV;
`endif
                    end else begin
                        load  = 1'b1;
                        res_d = alu_res;
                        ovf_d = alu_ovf;
                    end
                end
            end
            MUL: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                    load      = 1'b1;
                    res_d     = hi_sel ? mul_hi_n : mul_lo_n;
                end
            end
`ifdef PIPELINED_ALU_DIV_EN
            DIV: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = IDLE;
                    load      = 1'b1;
                    res_d     = hi_sel ? div_hi_n : div_lo_n;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opb       <= '0;
            hi        <= '0;
            lo        <= '0;
            hi_sel    <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE) begin
                if (accept && (is_mul || is_div)) begin
                    cnt    <= '0;
                    hi     <= '0;
                    hi_sel <= ALUControl[0];
`ifdef PIPELINED_ALU_DIV_EN
                    opb    <= is_div ? inB : inA;
                    lo     <= is_div ? inA : inB;
`else
                    opb    <= inA;
                    lo     <= inB;
`endif
                end
            end else if (state == MUL) begin
                hi  <= mul_hi_n;
                lo  <= mul_lo_n;
                cnt <= cnt + 1'b1;
            end
`ifdef PIPELINED_ALU_DIV_EN
            else if (state == DIV) begin
                hi  <= div_hi_n;
                lo  <= div_lo_n;
                cnt <= cnt + 1'b1;
            end
`endif

            if (load) begin
                out       <= res_d;
                zero      <= (res_d == '0);
                overflow  <= ovf_d;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// tb/tb_pipelined_alu.sv - randomized and directed bench for pipelined_alu against a behavioural model
module tb_pipelined_alu;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  inA;
    logic [W-1:0]  inB;
    logic [3:0]    ALUControl;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic          zero;
    logic          overflow;
    logic          busy;

    pipelined_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .inA        (inA),
        .inB        (inB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .zero       (zero),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the visible result register plus one in-flight long operation.
    bit           m_valid;
    logic [W-1:0] m_out;
    bit           m_ovf;
    bit           m_busy;
    int           m_left;
    logic [W-1:0] m_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output bit v, output bit lng);
        logic [63:0] p;
        p   = 64'(a) * 64'(b);
        r   = '0;
        v   = 1'b0;
        lng = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a ^ b);
            4'd6:  begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  r = a << b[4:0];
            4'd9:  r = a >> b[4:0];
            4'd10: r = $signed(a) >>> b[4:0];
            4'd12: begin r = p[31:0];  lng = 1'b1; end
            4'd13: begin r = p[63:32]; lng = 1'b1; end
`ifdef PIPELINED_ALU_DIV_EN
            4'd14: begin r = (b == 0) ? '1 : a / b; lng = 1'b1; end
            4'd15: begin r = (b == 0) ? a : a % b;  lng = 1'b1; end
`endif
            default: r = '0;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        bit v, l;
        ref_op(op, a, b, r, v, l);
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_out = '0; m_ovf = 0; m_busy = 0; m_left = 0; m_pend = '0;
    endtask

    // One clock cycle: drive inputs at the falling edge, compare all outputs against the
    // model, then advance the model to what the next rising edge must produce.
    task automatic step(input bit iv, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit ordy);
        bit rdy, load, v, lng;
        logic [W-1:0] r;
        @(negedge clk);
        in_valid = iv; ALUControl = op; inA = a; inB = b; out_ready = ordy;
        #1;
        rdy = !m_busy && (!m_valid || ordy);
        chk("out_valid", out_valid, m_valid);
        chk("busy", busy, m_busy);
        chk("in_ready", in_ready, rdy);
        if (m_valid) begin
            chk("out", out, m_out);
            chk("zero", zero, (m_out == 0));
            chk("overflow", overflow, m_ovf);
        end
        load = 0;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0; load = 1; r = m_pend; v = 0;
            end
        end else if (iv && rdy) begin
            ref_op(op, a, b, r, v, lng);
            if (lng) begin
                m_busy = 1; m_left = W; m_pend = r;
            end else begin
                load = 1;
            end
        end
        if (load) begin
            m_valid = 1; m_out = r; m_ovf = v;
        end else if (ordy) begin
            m_valid = 0;
        end
    endtask

    // Issue one operation, hold the result until it appears, pin value and latency.
    task automatic do_op(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int exp_lat);
        int n;
        n = 0;
        step(1, op, a, b, 1);
        for (int k = 1; k <= 40; k++) begin
            step(0, 4'd0, '0, '0, 0);
            if (out_valid) begin
                n = k;
                break;
            end
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_out"}, out, exp);
        step(0, 4'd0, '0, '0, 1);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0; in_valid = 0; inA = '0; inB = '0; ALUControl = '0; out_ready = 0;
        model_reset();

        // Model pinned to hand-computed values.
        chk("model_add", ref_res(4'd2, 32'h7FFF_FFFF, 32'h1), 32'h8000_0000);
        chk("model_mulhu", ref_res(4'd13, '1, '1), 32'hFFFF_FFFE);
        chk("model_sra", ref_res(4'd10, 32'h8000_0000, 32'd4), 32'hF800_0000);
        chk("model_slt", ref_res(4'd7, '1, 32'd1), 32'd1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_zero", zero, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Signed overflow on ADD.
        step(1, 4'd2, 32'h7FFF_FFFF, 32'h1, 1);
        step(0, 4'd0, '0, '0, 1);
        chk("add_valid", out_valid, 1);
        chk("add_out", out, 32'h8000_0000);
        chk("add_ovf", overflow, 1);
        chk("add_zero", zero, 0);

        // Back-to-back SUB then SLT.
        step(1, 4'd6, 32'd5, 32'd5, 1);
        step(1, 4'd7, '1, 32'd1, 1);
        chk("sub_valid", out_valid, 1);
        chk("sub_out", out, 0);
        chk("sub_zero", zero, 1);
        chk("b2b_in_ready", in_ready, 1);
        step(0, 4'd0, '0, '0, 1);
        chk("slt_valid", out_valid, 1);
        chk("slt_out", out, 1);
        step(0, 4'd0, '0, '0, 1);

        // Iterative multiply.
        step(1, 4'd13, '1, '1, 1);
        step(0, 4'd0, '0, '0, 0);
        chk("mul_busy", busy, 1);
        chk("mul_in_ready", in_ready, 0);
        begin
            int n;
            n = 1;
            for (int k = 2; k <= 40 && !out_valid; k++) begin
                step(0, 4'd0, '0, '0, 0);
                n = k;
            end
            chk("mulhu_latency", n, 33);
            chk("mulhu_out", out, 32'hFFFF_FFFE);
            step(0, 4'd0, '0, '0, 1);
        end
        do_op("mullo", 4'd12, 32'd12345, 32'd678, 32'd8369910, 33);

`ifdef PIPELINED_ALU_DIV_EN
        do_op("divu", 4'd14, 32'd100, 32'd7, 32'd14, 33);
        do_op("remu", 4'd15, 32'd100, 32'd7, 32'd2, 33);
        do_op("divu0", 4'd14, 32'd9, 32'd0, 32'hFFFF_FFFF, 33);
        do_op("remu0", 4'd15, 32'd9, 32'd0, 32'd9, 33);
`else
        do_op("divu_off", 4'd14, 32'd100, 32'd7, 32'd0, 1);
`endif

        // Stalled result must hold.
        step(1, 4'd10, 32'h8000_0000, 32'd4, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 4'd0, '0, '0, 0);
            chk("sra_out", out, 32'hF800_0000);
            chk("sra_valid", out_valid, 1);
            chk("sra_in_ready", in_ready, 0);
        end
        step(0, 4'd0, '0, '0, 1);
        chk("sra_release_ready", in_ready, 1);
        step(0, 4'd0, '0, '0, 1);
        chk("sra_consumed", out_valid, 0);

        // Reset in the middle of a multiply.
        step(1, 4'd12, '1, 32'd3, 1);
        for (int k = 0; k < 9; k++) step(0, 4'd0, '0, '0, 1);
        @(negedge clk);
        in_valid = 0;
        reset_n = 0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out", out, 0);
        chk("mrst_zero", zero, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("mrst_in_ready", in_ready, 1);
        for (int k = 0; k < 40; k++) step(0, 4'd0, '0, '0, 1);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
                 $urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < 40; k++) step(0, 4'd0, '0, '0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
